plru_tree_unit: RTL and testbench

//  Per-set tree pseudo-LRU engine for N-way set-associative caches.
//  - Holds the PLRU tree bits for every set and updates them on each hit or fill.
//  - Returns a registered victim way on request; an invalid way is always chosen first.
//  - Provides a sequenced flush that clears the tree state for all sets.
//  - Sits between the cache datapath (tag/valid arrays) and the cache control FSM.

---
 rtl/lc3b_types.sv | 12 +
 rtl/plru_tree_walk.sv | 77 +++++++
 rtl/plru_tree_unit.sv | 123 ++++++++++++
 tb/tb_plru_tree_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared cache-control types: PLRU engine FSM state encoding.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package lc3b_types;

    // PLRU_IDLE accepts lookups/touches; PLRU_FLUSH walks every set clearing its tree.
    typedef enum logic {
        PLRU_IDLE  = 1'b0,
        PLRU_FLUSH = 1'b1
    } plru_fsm_t;

endpackage

// File: rtl/plru_tree_walk.sv
// Combinational PLRU tree walker: victim select for one set, plus the tree image after touching a way.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs every cycle.
//
// Ports:
//   tree_bits  in  WAYS-1  heap-ordered node bits (node 0 = root, children 2i+1 lower / 2i+2 upper)
//   valid_mask in  WAYS    valid bit per way; any clear bit forces the lowest invalid way
//   touch_way  in  WAY_W   way being made MRU
//   victim_way out WAY_W   way to replace
//   next_tree  out WAYS-1  tree_bits with every node on touch_way's path pointing away from it
module plru_tree_walk #(
    parameter int WAYS  = 4,
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  tree_bits,
    input  logic [WAYS-1:0]  valid_mask,
    input  logic [WAY_W-1:0] touch_way,
    output logic [WAY_W-1:0] victim_way,
    output logic [WAYS-2:0]  next_tree
);

    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] walk_way;
    logic             node_bit;
    int               sel_node;
    int               upd_node;
    logic             dir;

    // Victim select. Node bit 0 sends the walk to the upper child, 1 to the lower
    // child, so each way bit (MSB first) is simply the inverted node bit.
    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_mask[i]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(i);
            end
        end

        walk_way = '0;
        sel_node = 0;
        node_bit = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            node_bit = 1'b0;
            // Constant-index scan avoids a variable bit-select on a tiny vector.
            for (int n = 0; n < WAYS - 1; n++) begin
                if (n == sel_node) begin
                    node_bit = tree_bits[n];
                end
            end
            walk_way[WAY_W-1-l] = ~node_bit;
            sel_node = 2 * sel_node + (node_bit ? 1 : 2);
        end

        victim_way = inv_found ? inv_way : walk_way;
    end

    // Touch update: a node above a lower-half way becomes 0 (victim goes upper),
    // above an upper-half way becomes 1, i.e. the node bit equals the way bit.
    always_comb begin
        next_tree = tree_bits;
        upd_node  = 0;
        dir       = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            dir = touch_way[WAY_W-1-l];
            for (int n = 0; n < WAYS - 1; n++) begin
                if (n == upd_node) begin
                    next_tree[n] = dir;
                end
            end
            upd_node = 2 * upd_node + (dir ? 2 : 1);
        end
    end

endmodule

// File: rtl/plru_tree_unit.sv
// Per-set tree pseudo-LRU engine: holds tree bits for all sets, returns victims, updates on touch, flushes.
// Latency: victim_valid/victim_way registered one cycle after lookup_valid; touch visible next cycle.
// Backpressure: none; during a flush (flush_busy=1) lookups, touches and flush re-pulses are dropped.
//
// Ports:
//   clk, rst_n                async active-low reset
//   lookup_valid/index        request a victim for a set; valid_mask gives that set's way valid bits
//   access_valid/index/way    hit or fill: mark way MRU in the set
//   flush                     single-cycle pulse, clears every set's tree over SETS cycles
//   victim_valid, victim_way  registered victim result (victim_way holds between lookups)
//   flush_busy                high for exactly SETS cycles after an accepted flush pulse
module plru_tree_unit
    import lc3b_types::*;
#(
    parameter int WAYS  = 4,
    parameter int SETS  = 8,
    parameter int IDX_W = $clog2(SETS),
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lookup_valid,
    input  logic [IDX_W-1:0] lookup_index,
    input  logic [WAYS-1:0]  valid_mask,
    input  logic             access_valid,
    input  logic [IDX_W-1:0] access_index,
    input  logic [WAY_W-1:0] access_way,
    input  logic             flush,
    output logic             victim_valid,
    output logic [WAY_W-1:0] victim_way,
    output logic             flush_busy
);

    logic [WAYS-2:0]  tree_q [SETS];
    plru_fsm_t        state_q;
    logic [IDX_W-1:0] flush_cnt_q;

    logic             idle;
    logic             access_ok;
    logic             lookup_ok;
    logic [WAYS-2:0]  upd_tree;
    logic [WAYS-2:0]  sel_tree;
    logic [WAY_W-1:0] sel_victim;
    logic [WAY_W-1:0] unused_upd_victim;
    logic [WAYS-2:0]  unused_sel_next;

    assign idle      = (state_q == PLRU_IDLE);
    assign access_ok = access_valid & idle;
    assign lookup_ok = lookup_valid & idle;

    // Update walker: new tree image for the touched set.
    plru_tree_walk #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_update_walk (
        .tree_bits  (tree_q[access_index]),
        .valid_mask ({WAYS{1'b1}}),
        .touch_way  (access_way),
        .victim_way (unused_upd_victim),
        .next_tree  (upd_tree)
    );

    // Same-cycle touch of the looked-up set is bypassed in, so a just-touched
    // valid way can never come back as the victim.
    assign sel_tree = (access_ok && (access_index == lookup_index)) ? upd_tree
                                                                   : tree_q[lookup_index];

    // Select walker: victim for the looked-up set.
    plru_tree_walk #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_select_walk (
        .tree_bits  (sel_tree),
        .valid_mask (valid_mask),
        .touch_way  ('0),
        .victim_way (sel_victim),
        .next_tree  (unused_sel_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                tree_q[s] <= '0;
            end
            state_q      <= PLRU_IDLE;
            flush_cnt_q  <= '0;
            flush_busy   <= 1'b0;
            victim_valid <= 1'b0;
            victim_way   <= '0;
        end else begin
            victim_valid <= lookup_ok;
            if (lookup_ok) begin
                victim_way <= sel_victim;
            end

            case (state_q)
                PLRU_IDLE: begin
                    if (access_valid) begin
                        tree_q[access_index] <= upd_tree;
                    end
                    if (flush) begin
                        state_q     <= PLRU_FLUSH;
                        flush_cnt_q <= '0;
                        flush_busy  <= 1'b1;
                    end
                end
                PLRU_FLUSH: begin
                    // One set per cycle; flush pulses here are ignored (no restart).
                    tree_q[flush_cnt_q] <= '0;
                    flush_cnt_q         <= flush_cnt_q + 1'b1;
                    if (flush_cnt_q == IDX_W'(SETS - 1)) begin
                        state_q    <= PLRU_IDLE;
                        flush_busy <= 1'b0;
                    end
                end
                default: begin
                    state_q <= PLRU_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plru_tree_unit.sv
// Self-checking bench for plru_tree_unit (WAYS=4/SETS=8 main instance, WAYS=8 secondary instance).
// Latency: expects victim one cycle after lookup, flush_busy for exactly SETS cycles.
// Backpressure: drives inputs freely; model drops requests while a flush is in progress.
module tb_plru_tree_unit;

    localparam int SETS = 8;
    localparam int WAYS = 4;

    logic       clk;
    logic       rst_n;
    logic       lookup_valid;
    logic [2:0] lookup_index;
    logic [3:0] valid_mask;
    logic       access_valid;
    logic [2:0] access_index;
    logic [1:0] access_way;
    logic       flush;
    logic       victim_valid;
    logic [1:0] victim_way;
    logic       flush_busy;

    logic       l8_lookup_valid;
    logic [2:0] l8_lookup_index;
    logic [7:0] l8_valid_mask;
    logic       l8_access_valid;
    logic [2:0] l8_access_index;
    logic [2:0] l8_access_way;
    logic       l8_flush;
    logic       l8_victim_valid;
    logic [2:0] l8_victim_way;
    logic       l8_flush_busy;

    int checks;
    int errors;

    // Reference model: per-set, per-way time stamp of the most recent touch
    // (0 = untouched since reset/flush). A node points at the half NOT holding
    // the most recently touched way of its subtree; untouched subtree -> upper half.
    int unsigned stamp [SETS][16];
    int unsigned tnow;
    int          busy_left;
    int          last_way;

    plru_tree_unit #(.WAYS(4), .SETS(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_valid (lookup_valid),
        .lookup_index (lookup_index),
        .valid_mask   (valid_mask),
        .access_valid (access_valid),
        .access_index (access_index),
        .access_way   (access_way),
        .flush        (flush),
        .victim_valid (victim_valid),
        .victim_way   (victim_way),
        .flush_busy   (flush_busy)
    );

    plru_tree_unit #(.WAYS(8), .SETS(8)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_valid (l8_lookup_valid),
        .lookup_index (l8_lookup_index),
        .valid_mask   (l8_valid_mask),
        .access_valid (l8_access_valid),
        .access_index (l8_access_index),
        .access_way   (l8_access_way),
        .flush        (l8_flush),
        .victim_valid (l8_victim_valid),
        .victim_way   (l8_victim_way),
        .flush_busy   (l8_flush_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_victim(input int unsigned row[16], input logic [15:0] mask,
                                        input int ways);
        int lo;
        int size;
        int half;
        int bw;
        int unsigned best;
        for (int i = 0; i < ways; i++) begin
            if (!mask[i]) return i;
        end
        lo   = 0;
        size = ways;
        while (size > 1) begin
            half = size / 2;
            best = 0;
            bw   = -1;
            for (int w = lo; w < lo + size; w++) begin
                if (row[w] > best) begin
                    best = row[w];
                    bw   = w;
                end
            end
            if (bw < 0 || bw < lo + half) lo = lo + half;
            size = half;
        end
        return lo;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < 16; w++) stamp[s][w] = 0;
        busy_left = 0;
        last_way  = 0;
    endtask

    // One clock: drive at posedge+1, advance model, check after the next edge.
    task automatic cycle(input logic lv, input int li, input logic [3:0] m,
                         input logic av, input int ai, input int aw, input logic fl);
        logic exp_vv;
        int unsigned row [16];
        lookup_valid = lv;
        lookup_index = 3'(li);
        valid_mask   = m;
        access_valid = av;
        access_index = 3'(ai);
        access_way   = 2'(aw);
        flush        = fl;
        exp_vv       = 1'b0;
        if (busy_left == 0) begin
            if (av) begin
                tnow++;
                stamp[ai][aw] = tnow;
            end
            if (lv) begin
                for (int w = 0; w < 16; w++) row[w] = stamp[li][w];
                exp_vv   = 1'b1;
                last_way = model_victim(row, {12'hFFF, m}, WAYS);
            end
            if (fl) begin
                for (int s = 0; s < SETS; s++)
                    for (int w = 0; w < 16; w++) stamp[s][w] = 0;
                busy_left = SETS;
            end
        end else begin
            busy_left--;
        end
        @(posedge clk);
        #1;
        check_eq("victim_valid", 32'(victim_valid), 32'(exp_vv));
        check_eq("victim_way", 32'(victim_way), 32'(last_way));
        check_eq("flush_busy", 32'(flush_busy), 32'(busy_left > 0));
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 0, 4'hF, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        tnow   = 0;
        model_reset();
        rst_n = 1'b0;
        lookup_valid = 1'b0; lookup_index = '0; valid_mask = 4'hF;
        access_valid = 1'b0; access_index = '0; access_way = '0; flush = 1'b0;
        l8_lookup_valid = 1'b0; l8_lookup_index = '0; l8_valid_mask = 8'hFF;
        l8_access_valid = 1'b0; l8_access_index = '0; l8_access_way = '0; l8_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_victim_valid", 32'(victim_valid), 32'd0);
        check_eq("rst_victim_way", 32'(victim_way), 32'd0);
        check_eq("rst_flush_busy", 32'(flush_busy), 32'd0);
        rst_n = 1'b1;
        idle_cycle();

        // Fresh set selects the top way.
        cycle(1'b1, 0, 4'hF, 1'b0, 0, 0, 1'b0);
        check_eq("t1_victim", 32'(victim_way), 32'd3);

        // Set 2 history.
        cycle(1'b0, 0, 4'hF, 1'b1, 2, 3, 1'b0);
        cycle(1'b1, 2, 4'hF, 1'b0, 0, 0, 1'b0);
        check_eq("t2_victim_a", 32'(victim_way), 32'd1);
        cycle(1'b0, 0, 4'hF, 1'b1, 2, 1, 1'b0);
        cycle(1'b1, 2, 4'hF, 1'b0, 0, 0, 1'b0);
        check_eq("t2_victim_b", 32'(victim_way), 32'd2);
        idle_cycle();
        check_eq("hold_victim_way", 32'(victim_way), 32'd2);

        // Invalid ways win.
        cycle(1'b1, 2, 4'b1011, 1'b0, 0, 0, 1'b0);
        check_eq("t3_mask1011", 32'(victim_way), 32'd2);
        cycle(1'b1, 2, 4'b0000, 1'b0, 0, 0, 1'b0);
        check_eq("t3_mask0000", 32'(victim_way), 32'd0);

        // Same-cycle touch + lookup bypass; neighbour set untouched.
        cycle(1'b1, 5, 4'hF, 1'b1, 5, 3, 1'b0);
        check_eq("t4_bypass", 32'(victim_way), 32'd1);
        cycle(1'b1, 4, 4'hF, 1'b0, 0, 0, 1'b0);
        check_eq("t4_other_set", 32'(victim_way), 32'd3);

        // Flush: touch all sets, pulse, count busy cycles, requests ignored.
        for (int s = 0; s < SETS; s++) cycle(1'b0, 0, 4'hF, 1'b1, s, $urandom_range(0, 3), 1'b0);
        cycle(1'b0, 0, 4'hF, 1'b0, 0, 0, 1'b1);
        n = 0;
        while (flush_busy && n < 20) begin
            if (n < 2) cycle(1'b1, n, 4'hF, 1'b1, n, 1, (n == 1));
            else idle_cycle();
            n++;
        end
        check_eq("t5_busy_cycles", 32'(n), 32'd8);
        for (int s = 0; s < SETS; s++) begin
            cycle(1'b1, s, 4'hF, 1'b0, 0, 0, 1'b0);
            check_eq("t5_post_flush", 32'(victim_way), 32'd3);
        end

        // Randomized traffic against the model, including collisions and flushes.
        for (int k = 0; k < 800; k++) begin
            int li;
            int ai;
            logic [3:0] m;
            li = $urandom_range(0, SETS - 1);
            ai = ($urandom_range(0, 2) == 0) ? li : $urandom_range(0, SETS - 1);
            m  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            cycle(1'($urandom), li, m, 1'($urandom), ai, $urandom_range(0, 3),
                  ($urandom_range(0, 39) == 0));
        end
        while (busy_left > 0) idle_cycle();

        // Asynchronous reset in the middle of a flush.
        cycle(1'b0, 0, 4'hF, 1'b0, 0, 0, 1'b1);
        repeat (3) idle_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_busy", 32'(flush_busy), 32'd0);
        check_eq("t6_async_way", 32'(victim_way), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 0, 4'hF, 1'b0, 0, 0, 1'b0);
        check_eq("t6_after_rst", 32'(victim_way), 32'd3);

        // WAYS=8 instance: fresh set -> way 7; touch way 7 with same-cycle lookup -> way 3.
        l8_lookup_valid = 1'b1; l8_lookup_index = 3'd0; l8_valid_mask = 8'hFF;
        @(posedge clk);
        #1;
        l8_lookup_valid = 1'b0;
        check_eq("w8_valid", 32'(l8_victim_valid), 32'd1);
        check_eq("w8_fresh", 32'(l8_victim_way), 32'd7);
        l8_lookup_valid = 1'b1; l8_lookup_index = 3'd1;
        l8_access_valid = 1'b1; l8_access_index = 3'd1; l8_access_way = 3'd7;
        @(posedge clk);
        #1;
        l8_lookup_valid = 1'b0;
        l8_access_valid = 1'b0;
        check_eq("w8_bypass", 32'(l8_victim_way), 32'd3);
        @(posedge clk);
        #1;
        check_eq("w8_idle_valid", 32'(l8_victim_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
